// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// standard bundle widths, the NOP control word and the skid-buffer state type.
package pipe_pkg;

    localparam int ID_EX_CTRL_W = 16;
    // RD1, RD2, Imm, PC, PC+4 (5 x 32) would exceed this; the core packs PC+4 implicitly
    localparam int ID_EX_DATA_W = 133;

    localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Main + skid register pair for the elastic stage. in_ready depends only on
// registered state, so the upstream ready path is cut at this stage.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W         = ID_EX_CTRL_W,
    parameter int DATA_W         = 128,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              drain_i,
    output logic              in_ready_o,
    output logic              main_v_o,
    output logic              skid_v_o,
    output logic [CTRL_W-1:0] main_ctrl_o,
    output logic [DATA_W-1:0] main_data_o
);

    skid_state_e       state_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              accept;

    assign in_ready_o = reset_n & ~flush_i & (state_q != ST_FULL);
    assign accept     = in_valid_i & in_ready_o;

    // The skid entry is always older than any new input, so FULL only ever drains skid into main.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else if (flush_i) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            if (FLUSH_CLR_DATA != 0) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_q <= in_ctrl_i;
                        main_data_q <= in_data_i;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain_i) begin
                        main_ctrl_q <= in_ctrl_i;
                        main_data_q <= in_data_i;
                    end else if (accept) begin
                        skid_ctrl_q <= in_ctrl_i;
                        skid_data_q <= in_data_i;
                        state_q     <= ST_FULL;
                    end else if (drain_i) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain_i) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        state_q     <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign main_v_o    = (state_q != ST_EMPTY);
    assign skid_v_o    = (state_q == ST_FULL);
    assign main_ctrl_o = main_ctrl_q;
    assign main_data_o = main_data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Parametrised elastic pipeline register between two core stages, with
// stall, flush-to-NOP, optional skid buffer and a saturating flush-kill counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W         = ID_EX_CTRL_W,
    parameter int DATA_W         = 128,
    parameter int SKID           = 1,
    parameter int FLUSH_CLR_DATA = 0,
    parameter int CNT_W          = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_kills
);

    logic              main_v;
    logic              skid_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              drain;
    logic              kill;
    logic [CNT_W-1:0]  flush_kills_q;

    assign drain = main_v & out_ready & ~stall;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(
                .CTRL_W         (CTRL_W),
                .DATA_W         (DATA_W),
                .FLUSH_CLR_DATA (FLUSH_CLR_DATA)
            ) u_skid_buf (
                .clock       (clock),
                .reset_n     (reset_n),
                .flush_i     (flush),
                .in_valid_i  (in_valid),
                .in_ctrl_i   (in_ctrl),
                .in_data_i   (in_data),
                .drain_i     (drain),
                .in_ready_o  (in_ready),
                .main_v_o    (main_v),
                .skid_v_o    (skid_v),
                .main_ctrl_o (main_ctrl),
                .main_data_o (main_data)
            );
        end else begin : g_single
            logic              main_v_q;
            logic [CTRL_W-1:0] main_ctrl_q;
            logic [DATA_W-1:0] main_data_q;
            logic              accept;

            // Single register: ready passes combinationally from downstream.
            assign in_ready = reset_n & ~flush & (~main_v_q | (out_ready & ~stall));
            assign accept   = in_valid & in_ready;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    main_v_q    <= 1'b0;
                    main_ctrl_q <= '0;
                    main_data_q <= '0;
                end else if (flush) begin
                    main_v_q    <= 1'b0;
                    main_ctrl_q <= '0;
                    if (FLUSH_CLR_DATA != 0) begin
                        main_data_q <= '0;
                    end
                end else if (accept) begin
                    main_v_q    <= 1'b1;
                    main_ctrl_q <= in_ctrl;
                    main_data_q <= in_data;
                end else if (drain) begin
                    main_v_q <= 1'b0;
                end
            end

            assign main_v    = main_v_q;
            assign skid_v    = 1'b0;
            assign main_ctrl = main_ctrl_q;
            assign main_data = main_data_q;
        end
    endgenerate

    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    // An entry leaving downstream on the flush edge is delivered, not killed.
    assign kill = flush & (occupancy > {1'b0, drain});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush_kills_q <= '0;
        end else if (kill && (flush_kills_q != {CNT_W{1'b1}})) begin
            flush_kills_q <= flush_kills_q + CNT_W'(1);
        end
    end

    assign out_valid   = main_v;
    assign out_ctrl    = main_v ? main_ctrl : NOP_CTRL[CTRL_W-1:0];
    assign out_data    = main_data;
    assign flush_kills = flush_kills_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a SKID=1/keep-data instance and a
// SKID=0/clear-data instance share stimulus; each table checks one of them.
module tb_pipe_stage_elastic;

    localparam int CW = 16;
    localparam int DW = 32;
    localparam int NW = 8;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          stall;
    logic          flush;

    logic          inReady0, outValid0, inReady1, outValid1;
    logic [CW-1:0] outCtrl0, outCtrl1;
    logic [DW-1:0] outData0, outData1;
    logic [1:0]    occ0, occ1;
    logic [NW-1:0] kills0, kills1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic          iv;
        logic [CW-1:0] ictrl;
        logic [DW-1:0] idata;
        logic          ordy;
        logic          stl;
        logic          fl;
        logic          eRdy;
        logic          eValid;
        logic [CW-1:0] eCtrl;
        logic [DW-1:0] eData;
        logic [1:0]    eOcc;
    } vec_t;

    vec_t skidTab[18];
    vec_t singleTab[10];

    pipe_stage_elastic #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(1), .FLUSH_CLR_DATA(0), .CNT_W(NW)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(inReady0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(outValid0), .out_ready(out_ready),
        .out_ctrl(outCtrl0), .out_data(outData0), .stall(stall), .flush(flush),
        .occupancy(occ0), .flush_kills(kills0)
    );

    pipe_stage_elastic #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(0), .FLUSH_CLR_DATA(1), .CNT_W(NW)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(inReady1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(outValid1), .out_ready(out_ready),
        .out_ctrl(outCtrl1), .out_data(outData1), .stall(stall), .flush(flush),
        .occupancy(occ1), .flush_kills(kills1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic iv, input logic [CW-1:0] ictrl, input logic [DW-1:0] idata,
                                input logic ordy, input logic stl, input logic fl,
                                input logic eRdy, input logic eValid, input logic [CW-1:0] eCtrl,
                                input logic [DW-1:0] eData, input logic [1:0] eOcc);
        vec_t v;
        v.iv = iv; v.ictrl = ictrl; v.idata = idata; v.ordy = ordy; v.stl = stl; v.fl = fl;
        v.eRdy = eRdy; v.eValid = eValid; v.eCtrl = eCtrl; v.eData = eData; v.eOcc = eOcc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ictrl, input logic [DW-1:0] idata,
                         input logic ordy, input logic stl, input logic fl);
        in_valid = iv; in_ctrl = ictrl; in_data = idata;
        out_ready = ordy; stall = stl; flush = fl;
    endtask

    // in_ready is checked before the edge (it may be combinational), the rest after it.
    task automatic applyStimulus(input vec_t v, input int sel, input int idx);
        drive(v.iv, v.ictrl, v.idata, v.ordy, v.stl, v.fl);
        #1;
        checkOutput($sformatf("d%0d.v%0d in_ready", sel, idx), 32'(sel == 0 ? inReady0 : inReady1), 32'(v.eRdy));
        @(posedge clock);
        #1;
        checkOutput($sformatf("d%0d.v%0d out_valid", sel, idx), 32'(sel == 0 ? outValid0 : outValid1), 32'(v.eValid));
        checkOutput($sformatf("d%0d.v%0d out_ctrl", sel, idx), 32'(sel == 0 ? outCtrl0 : outCtrl1), 32'(v.eCtrl));
        checkOutput($sformatf("d%0d.v%0d out_data", sel, idx), sel == 0 ? outData0 : outData1, v.eData);
        checkOutput($sformatf("d%0d.v%0d occupancy", sel, idx), 32'(sel == 0 ? occ0 : occ1), 32'(v.eOcc));
    endtask

    initial begin
        //                 iv  ictrl     idata  ordy stl fl  rdy val  ctrl     data   occ
        skidTab[0]  = mk(1, 16'h00A5, 32'h01, 1, 0, 0, 1, 1, 16'h00A5, 32'h01, 2'd1);
        skidTab[1]  = mk(0, 16'h0000, 32'h00, 1, 0, 0, 1, 0, 16'h0000, 32'h01, 2'd0);
        skidTab[2]  = mk(1, 16'h0011, 32'hAA, 0, 0, 0, 1, 1, 16'h0011, 32'hAA, 2'd1);
        skidTab[3]  = mk(1, 16'h0022, 32'hBB, 0, 0, 0, 1, 1, 16'h0011, 32'hAA, 2'd2);
        skidTab[4]  = mk(1, 16'h0033, 32'hCC, 0, 0, 0, 0, 1, 16'h0011, 32'hAA, 2'd2);
        skidTab[5]  = mk(1, 16'h0033, 32'hCC, 1, 0, 0, 0, 1, 16'h0022, 32'hBB, 2'd1);
        skidTab[6]  = mk(0, 16'h0000, 32'h00, 1, 0, 0, 1, 0, 16'h0000, 32'hBB, 2'd0);
        skidTab[7]  = mk(1, 16'h0044, 32'h44, 1, 0, 0, 1, 1, 16'h0044, 32'h44, 2'd1);
        skidTab[8]  = mk(1, 16'h0055, 32'h55, 1, 1, 0, 1, 1, 16'h0044, 32'h44, 2'd2);
        skidTab[9]  = mk(0, 16'h0000, 32'h00, 1, 1, 0, 0, 1, 16'h0044, 32'h44, 2'd2);
        skidTab[10] = mk(0, 16'h0000, 32'h00, 1, 1, 0, 0, 1, 16'h0044, 32'h44, 2'd2);
        skidTab[11] = mk(0, 16'h0000, 32'h00, 1, 0, 0, 0, 1, 16'h0055, 32'h55, 2'd1);
        skidTab[12] = mk(1, 16'h0066, 32'h66, 1, 0, 0, 1, 1, 16'h0066, 32'h66, 2'd1);
        skidTab[13] = mk(1, 16'h0077, 32'h77, 0, 0, 0, 1, 1, 16'h0066, 32'h66, 2'd2);
        skidTab[14] = mk(1, 16'h0088, 32'h88, 0, 0, 1, 0, 0, 16'h0000, 32'h66, 2'd0);
        skidTab[15] = mk(1, 16'h0099, 32'h99, 1, 0, 0, 1, 1, 16'h0099, 32'h99, 2'd1);
        skidTab[16] = mk(0, 16'h0000, 32'h00, 1, 0, 1, 0, 0, 16'h0000, 32'h99, 2'd0);
        skidTab[17] = mk(1, 16'h0010, 32'h10, 1, 1, 1, 0, 0, 16'h0000, 32'h99, 2'd0);

        singleTab[0] = mk(1, 16'h00A5, 32'h01, 1, 0, 0, 1, 1, 16'h00A5, 32'h01, 2'd1);
        singleTab[1] = mk(1, 16'h0011, 32'hAA, 1, 0, 0, 1, 1, 16'h0011, 32'hAA, 2'd1);
        singleTab[2] = mk(1, 16'h0022, 32'hBB, 0, 0, 0, 0, 1, 16'h0011, 32'hAA, 2'd1);
        singleTab[3] = mk(1, 16'h0022, 32'hBB, 1, 1, 0, 0, 1, 16'h0011, 32'hAA, 2'd1);
        singleTab[4] = mk(1, 16'h0022, 32'hBB, 1, 1, 0, 0, 1, 16'h0011, 32'hAA, 2'd1);
        singleTab[5] = mk(1, 16'h0022, 32'hBB, 1, 1, 0, 0, 1, 16'h0011, 32'hAA, 2'd1);
        singleTab[6] = mk(0, 16'h0000, 32'h00, 0, 0, 1, 0, 0, 16'h0000, 32'h00, 2'd0);
        singleTab[7] = mk(1, 16'h0033, 32'hCC, 0, 0, 0, 1, 1, 16'h0033, 32'hCC, 2'd1);
        singleTab[8] = mk(0, 16'h0000, 32'h00, 1, 0, 0, 1, 0, 16'h0000, 32'hCC, 2'd0);
        singleTab[9] = mk(1, 16'h0044, 32'hDD, 1, 0, 1, 0, 0, 16'h0000, 32'h00, 2'd0);

        drive(0, '0, '0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset out_valid", 32'(outValid0), 32'd0);
        checkOutput("reset out_ctrl", 32'(outCtrl0), 32'd0);
        checkOutput("reset out_data", outData0, 32'd0);
        checkOutput("reset occupancy", 32'(occ0), 32'd0);
        checkOutput("reset in_ready", 32'(inReady0), 32'd0);
        checkOutput("reset flush_kills", 32'(kills0), 32'd0);
        checkOutput("reset d1 in_ready", 32'(inReady1), 32'd0);
        checkOutput("reset d1 out_valid", 32'(outValid1), 32'd0);

        reset_n = 1'b1;
        #1;
        checkOutput("release in_ready", 32'(inReady0), 32'd1);
        checkOutput("release d1 in_ready", 32'(inReady1), 32'd1);

        // Flushing an empty stage never counts as a kill.
        drive(0, '0, '0, 0, 0, 1);
        repeat (300) @(posedge clock);
        #1;
        drive(0, '0, '0, 0, 0, 0);
        checkOutput("empty flush kills d0", 32'(kills0), 32'd0);
        checkOutput("empty flush kills d1", 32'(kills1), 32'd0);
        checkOutput("empty flush occupancy", 32'(occ0), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(singleTab[i], 1, i);
        checkOutput("single flush_kills", 32'(kills1), 32'd1);

        drive(0, '0, '0, 0, 0, 0);
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) applyStimulus(skidTab[i], 0, i);
        checkOutput("skid flush_kills", 32'(kills0), 32'd1);

        for (int i = 0; i < 300; i++) begin
            drive(1, 16'h0001, 32'h1, 0, 0, 0);
            @(posedge clock);
            #1;
            drive(0, '0, '0, 0, 0, 1);
            @(posedge clock);
            #1;
        end
        drive(0, '0, '0, 0, 0, 0);
        checkOutput("saturate kills d0", 32'(kills0), 32'd255);
        checkOutput("saturate kills d1", 32'(kills1), 32'd255);

        // Fill the skid stage, then drop reset between edges.
        drive(1, 16'h0BAD, 32'h1234, 0, 0, 0);
        @(posedge clock);
        #1;
        in_ctrl = 16'h0C0D;
        @(posedge clock);
        #1;
        checkOutput("prefill occupancy", 32'(occ0), 32'd2);
        checkOutput("prefill out_ctrl", 32'(outCtrl0), 32'h0BAD);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(outValid0), 32'd0);
        checkOutput("async out_ctrl", 32'(outCtrl0), 32'd0);
        checkOutput("async out_data", outData0, 32'd0);
        checkOutput("async occupancy", 32'(occ0), 32'd0);
        checkOutput("async flush_kills", 32'(kills0), 32'd0);
        checkOutput("async in_ready", 32'(inReady0), 32'd0);
        @(posedge clock);
        #1;
        drive(1, 16'h00E1, 32'hE1, 1, 0, 0);
        reset_n = 1'b1;
        #1;
        checkOutput("resume in_ready", 32'(inReady0), 32'd1);
        @(posedge clock);
        #1;
        checkOutput("resume out_valid", 32'(outValid0), 32'd1);
        checkOutput("resume out_ctrl", 32'(outCtrl0), 32'h00E1);
        checkOutput("resume occupancy", 32'(occ0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
